// File: rtl/icache_assoc.sv
// Set-associative instruction cache (1 or 2 ways, LRU, multi-word blocks, sequential refill).
// Optional feature: define ICACHE_FLUSH_EN to add the iflush port and whole-cache invalidate.
module icache_assoc #(
  parameter int CPUID       = 0,
  parameter int NSETS       = 8,
  parameter int WAYS        = 2,
  parameter int BLOCK_WORDS = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
`ifdef ICACHE_FLUSH_EN
  input  logic        iflush,
`endif
  input  logic [31:0] iload
);

  localparam int WOFF    = $clog2(BLOCK_WORDS);
  localparam int WW      = (WOFF == 0) ? 1 : WOFF;
  localparam int IDXW    = $clog2(NSETS);
  localparam int TAGW    = 32 - 2 - WOFF - IDXW;
  localparam int IDX_SH  = 2 + WOFF;
  localparam int TAG_SH  = 2 + WOFF + IDXW;

  typedef enum logic {ST_IDLE, ST_FILL} state_t;

  state_t            r_state, w_next;
  logic [TAGW-1:0]   r_tag_l;
  logic [IDXW-1:0]   r_idx_l;
  logic [WW-1:0]     r_cnt;
  logic              r_victim;

  logic [NSETS-1:0]  r_valid [WAYS];
  logic [TAGW-1:0]   r_tag   [WAYS][NSETS];
  logic [31:0]       r_data  [WAYS][NSETS][BLOCK_WORDS];

  logic [TAGW-1:0]   w_tag;
  logic [IDXW-1:0]   w_idx;
  logic [WW-1:0]     w_woff;
  logic [WAYS-1:0]   w_match;
  logic              w_any_match;
  logic              w_hit;
  logic              w_hit_way;
  logic              w_victim_sel;
  logic              w_flush;
  logic              w_start;
  logic              w_fill_word;
  logic              w_fill_last;
  logic              w_unused;

`ifdef ICACHE_FLUSH_EN
  assign w_flush = iflush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_unused = ^{32'(CPUID)};

  assign w_tag  = TAGW'(imemaddr >> TAG_SH);
  assign w_idx  = IDXW'(imemaddr >> IDX_SH);
  assign w_woff = WW'((imemaddr >> 2) & 32'(BLOCK_WORDS - 1));

  for (genvar w = 0; w < WAYS; w++) begin : g_match
    assign w_match[w] = r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag);
  end

  assign w_any_match = |w_match;
  assign w_hit       = (r_state == ST_IDLE) && imemREN && w_any_match && !w_flush;

  // Replacement state: with two ways r_lru[set] names the least recently used way.
  if (WAYS == 2) begin : g_lru
    logic [NSETS-1:0] r_lru;

    assign w_hit_way    = w_match[1];
    assign w_victim_sel = !r_valid[0][w_idx] ? 1'b0 :
                          !r_valid[1][w_idx] ? 1'b1 : r_lru[w_idx];

    always_ff @(posedge CLK) begin
      if (RST || w_flush) begin
        r_lru <= '0;
      end else if (w_hit) begin
        r_lru[w_idx] <= ~w_hit_way;
      end else if (w_fill_last) begin
        r_lru[r_idx_l] <= ~r_victim;
      end
    end
  end else begin : g_direct
    assign w_hit_way    = 1'b0;
    assign w_victim_sel = 1'b0;
  end

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next      = r_state;
    w_start     = 1'b0;
    w_fill_word = 1'b0;
    w_fill_last = 1'b0;
    iREN        = 1'b0;
    iaddr       = imemaddr;
    case (r_state)
      ST_IDLE: begin
        if (imemREN && !w_any_match && !w_flush) begin
          w_start = 1'b1;
          w_next  = ST_FILL;
        end
      end
      ST_FILL: begin
        iREN  = 1'b1;
        iaddr = (32'(r_tag_l) << TAG_SH) | (32'(r_idx_l) << IDX_SH) | (32'(r_cnt) << 2);
        if (!iwait && !w_flush) begin
          w_fill_word = 1'b1;
          if (r_cnt == WW'(BLOCK_WORDS - 1)) begin
            w_fill_last = 1'b1;
            w_next      = ST_IDLE;
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
    if (w_flush) w_next = ST_IDLE;
  end

  always_comb begin
    ihit     = w_hit;
    imemload = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (w_hit && (w_hit_way == 1'(w))) imemload = r_data[w][w_idx][w_woff];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge CLK) begin
    if (RST || w_flush) begin
      for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
      r_cnt    <= '0;
      r_tag_l  <= '0;
      r_idx_l  <= '0;
      r_victim <= 1'b0;
    end else begin
      if (w_start) begin
        r_tag_l  <= w_tag;
        r_idx_l  <= w_idx;
        r_cnt    <= '0;
        r_victim <= w_victim_sel;
        for (int w = 0; w < WAYS; w++) begin
          if (w_victim_sel == 1'(w)) r_valid[w][w_idx] <= 1'b0;
        end
      end
      if (w_fill_word) begin
        r_cnt <= w_fill_last ? '0 : r_cnt + 1'b1;
        for (int w = 0; w < WAYS; w++) begin
          if (w_fill_last && (r_victim == 1'(w))) r_valid[w][r_idx_l] <= 1'b1;
        end
      end
    end
  end

  // NOTE: data and tag arrays carry no reset; the valid bits alone decide whether their contents are meaningful.
  always_ff @(posedge CLK) begin
    for (int w = 0; w < WAYS; w++) begin
      if (w_fill_word && (r_victim == 1'(w))) begin
        r_data[w][r_idx_l][r_cnt] <= iload;
        if (w_fill_last) r_tag[w][r_idx_l] <= r_tag_l;
      end
    end
  end

endmodule
